// File: rtl/usart_rx_sipo.sv
// USART receive shift register: oversampled start detect, bit-centre sampling, stop check.
// Optional even parity bit is compiled in when USART_RX_PARITY_EN is defined.
module usart_rx_sipo #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter string       DO_MSB_FIRST = "TRUE",
  parameter int unsigned OVERSAMPLE   = 16
) (
  input  logic                  clk_i,
  input  logic                  s_rst_i,
  input  logic                  tick_i,
  input  logic                  rx_i,
  input  logic                  rd_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic                  busy_o,
  output logic                  frame_err_o,
  output logic                  parity_err_o,
  output logic                  overrun_o
);

  localparam int unsigned TickW = $clog2(OVERSAMPLE);
  localparam int unsigned BitW  = $clog2(DATA_WIDTH + 1);
  localparam logic [TickW-1:0] TickHalf = TickW'(OVERSAMPLE / 2 - 1);
  localparam logic [TickW-1:0] TickFull = TickW'(OVERSAMPLE - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_WIDTH - 1);
  localparam bit MsbFirst = (DO_MSB_FIRST == "TRUE");

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef USART_RX_PARITY_EN
    StParity,
`endif
    StStop,
    StWaitHigh
  } state_e;

  state_e                state_q, state_d;
  logic                  rx_meta_q, rx_s_q;
  logic                  rx_prev_q, rx_prev_d;
  logic [TickW-1:0]      tick_cnt_q, tick_cnt_d;
  logic [BitW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overrun_q, overrun_d;
  logic                  good;
  logic                  par_bad;

`ifdef USART_RX_PARITY_EN
  logic par_bad_q, par_bad_d;
  logic parity_err_q, parity_err_d;

  assign par_bad      = par_bad_q;
  assign parity_err_o = parity_err_q;

  always_ff @(posedge clk_i) begin
    if (s_rst_i) begin
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
    end
  end
`else
  assign par_bad      = 1'b0;
  assign parity_err_o = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    rx_prev_d   = rx_prev_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    good        = 1'b0;
`ifdef USART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif
    if (rd_i) valid_d = 1'b0;

    if (tick_i) begin
      rx_prev_d  = rx_s_q;
      tick_cnt_d = tick_cnt_q + 1'b1;
      unique case (state_q)
        StIdle: begin
          if (!rx_s_q && rx_prev_q) begin
            state_d    = StStart;
            tick_cnt_d = '0;
          end
        end
        StStart: begin
          if (tick_cnt_q == TickHalf) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            state_d    = rx_s_q ? StIdle : StData;
          end
        end
        StData: begin
          if (tick_cnt_q == TickFull) begin
            tick_cnt_d = '0;
            bit_cnt_d  = bit_cnt_q + 1'b1;
            if (MsbFirst) shift_d = {shift_q[DATA_WIDTH-2:0], rx_s_q};
            else          shift_d = {rx_s_q, shift_q[DATA_WIDTH-1:1]};
            if (bit_cnt_q == BitLast) begin
`ifdef USART_RX_PARITY_EN
              state_d = StParity;
`else
              state_d = StStop;
`endif
            end
          end
        end
`ifdef USART_RX_PARITY_EN
        StParity: begin
          if (tick_cnt_q == TickFull) begin
            tick_cnt_d = '0;
            par_bad_d  = ^{shift_q, rx_s_q};
            state_d    = StStop;
          end
        end
`endif
        StStop: begin
          if (tick_cnt_q == TickFull) begin
            tick_cnt_d = '0;
`ifdef USART_RX_PARITY_EN
            parity_err_d = par_bad_q;
`endif
            if (rx_s_q) begin
              state_d = StIdle;
              good    = !par_bad;
            end else begin
              frame_err_d = 1'b1;
              state_d     = StWaitHigh;
            end
          end
        end
        StWaitHigh: begin
          // Stay here through a break; only a high line re-arms start detection.
          if (rx_s_q) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end

    if (good) begin
      if (!valid_q || rd_i) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (s_rst_i) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_prev_q   <= 1'b1;
      state_q     <= StIdle;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_meta_q   <= rx_i;
      rx_s_q      <= rx_meta_q;
      rx_prev_q   <= rx_prev_d;
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign busy_o      = (state_q != StIdle);
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_usart_rx_sipo.sv
// Scoreboard bench for usart_rx_sipo: MSB-first and LSB-first instances share one RX line.
// Frames add a parity bit when USART_RX_PARITY_EN is defined.
module tb_usart_rx_sipo;

  localparam int unsigned Dw      = 8;
  localparam int unsigned Os      = 16;
  localparam int unsigned TickDiv = 4;

  logic       clk_i = 1'b0;
  logic       s_rst_i, tick_i, rx_i, rd_i;
  logic [7:0] data_m, data_l;
  logic       valid_m, valid_l, busy_m, busy_l;
  logic       ferr_m, ferr_l, perr_m, perr_l, ovr_m, ovr_l;

  typedef struct packed {
    logic       load;
    logic       ovr;
    logic       ferr;
    logic       perr;
    logic [7:0] data;
  } ev_t;

  ev_t        sb_q[$];
  ev_t        mon_ev;
  int         errors = 0;
  int         checks = 0;
  int         tick_div_cnt = 0;
  bit         mvalid = 1'b0;
  logic [7:0] mdata = 8'h00;
  logic [3:0] obs_m, obs_l;
  logic [7:0] pdata_m = 8'h00, pdata_l = 8'h00;
  logic       pvalid_m = 1'b0, pvalid_l = 1'b0;

  usart_rx_sipo #(.DATA_WIDTH(Dw), .DO_MSB_FIRST("TRUE"), .OVERSAMPLE(Os)) dut (
    .clk_i(clk_i), .s_rst_i(s_rst_i), .tick_i(tick_i), .rx_i(rx_i), .rd_i(rd_i),
    .data_o(data_m), .valid_o(valid_m), .busy_o(busy_m), .frame_err_o(ferr_m),
    .parity_err_o(perr_m), .overrun_o(ovr_m)
  );

  usart_rx_sipo #(.DATA_WIDTH(Dw), .DO_MSB_FIRST("FALSE"), .OVERSAMPLE(Os)) dut_lsb (
    .clk_i(clk_i), .s_rst_i(s_rst_i), .tick_i(tick_i), .rx_i(rx_i), .rd_i(rd_i),
    .data_o(data_l), .valid_o(valid_l), .busy_o(busy_l), .frame_err_o(ferr_l),
    .parity_err_o(perr_l), .overrun_o(ovr_l)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    tick_i = 1'b0;
    forever begin
      @(negedge clk_i);
      tick_div_cnt++;
      tick_i = (tick_div_cnt % TickDiv == 0);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick_wait(input int n);
    for (int k = 0; k < n; k++) begin
      do @(posedge clk_i); while (tick_i !== 1'b1);
    end
  endtask

  task automatic drive(input logic b);
    #1;
    rx_i = b;
  endtask

  task automatic do_read();
    @(posedge clk_i);
    #1 rd_i = 1'b1;
    @(posedge clk_i);
    #1 rd_i = 1'b0;
    mvalid = 1'b0;
    chk("valid_after_read", valid_m, 0);
  endtask

  task automatic do_reset();
    @(posedge clk_i);
    #1 s_rst_i = 1'b1;
    @(posedge clk_i);
    @(posedge clk_i);
    #1 s_rst_i = 1'b0;
    mvalid = 1'b0;
    mdata  = 8'h00;
    sb_q.delete();
  endtask

  // Line word w goes out w[7] first; the model decides the outcome from frame-level rules.
  task automatic send_frame(input logic [7:0] w, input bit stop_val, input int stop_len,
                            input bit par_flip, input bit rd_at_stop);
    bit  par_ok, good, pre_valid;
    ev_t e;
    par_ok = 1'b1;
`ifdef USART_RX_PARITY_EN
    par_ok = !par_flip;
`endif
    good      = stop_val && par_ok;
    pre_valid = mvalid;
    e         = '0;
    e.ferr    = !stop_val;
    e.perr    = !par_ok;
    if (good) begin
      if (!mvalid || rd_at_stop) begin
        e.load = 1'b1;
        e.data = w;
        mvalid = 1'b1;
        mdata  = w;
      end else begin
        e.ovr = 1'b1;
      end
    end
    sb_q.push_back(e);

    drive(1'b0);
    tick_wait(Os);
    for (int i = Dw - 1; i >= 0; i--) begin
      drive(w[i]);
      tick_wait(Os);
    end
`ifdef USART_RX_PARITY_EN
    drive((^w) ^ par_flip);
    tick_wait(Os);
`endif
    drive(stop_val);
    // Stop sample is the (Os/2+1)-th tick of the stop bit; stand one clock before it.
    tick_wait(Os / 2);
    repeat (TickDiv - 1) @(posedge clk_i);
    #1;
    chk("valid_before_stop", valid_m, pre_valid);
    if (rd_at_stop) rd_i = 1'b1;
    @(posedge clk_i);
    #1 rd_i = 1'b0;
    chk("valid_after_stop", valid_m, mvalid);
    chk("ferr_at_stop", ferr_m, !stop_val);
    chk("perr_at_stop", perr_m, !par_ok);
    chk("ovr_at_stop", ovr_m, e.ovr);
    chk("busy_after_stop", busy_m, !stop_val);
    tick_wait(Os / 2 - 1);
    if (stop_len > 1) tick_wait(Os * (stop_len - 1));
    #1;
    chk("busy_before_release", busy_m, !stop_val);
    drive(1'b1);
    tick_wait(2);
    #1;
    chk("busy_idle", busy_m, 0);
    chk("sb_drained", sb_q.size(), 0);
  endtask

  always @(negedge clk_i) begin
    if (!s_rst_i) begin
      obs_m = {(valid_m && !pvalid_m) || (data_m != pdata_m), ovr_m, ferr_m, perr_m};
      obs_l = {(valid_l && !pvalid_l) || (data_l != pdata_l), ovr_l, ferr_l, perr_l};
      if (obs_m != 4'b0 || obs_l != 4'b0) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_event", {obs_m, obs_l}, 0);
        end else begin
          mon_ev = sb_q.pop_front();
          chk("event_msb", obs_m, {mon_ev.load, mon_ev.ovr, mon_ev.ferr, mon_ev.perr});
          chk("event_lsb", obs_l, {mon_ev.load, mon_ev.ovr, mon_ev.ferr, mon_ev.perr});
          if (mon_ev.load) begin
            chk("data_msb", data_m, mon_ev.data);
            chk("data_lsb", data_l, rev8(mon_ev.data));
          end
        end
      end
    end
    pdata_m  = data_m;
    pdata_l  = data_l;
    pvalid_m = valid_m;
    pvalid_l = valid_l;
  end

  initial begin
    logic [7:0] w;
    bit         sv;
    s_rst_i = 1'b1;
    rx_i    = 1'b1;
    rd_i    = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 s_rst_i = 1'b0;
    #1;
    chk("rst_data", {data_m, data_l}, 0);
    chk("rst_flags", {valid_m, busy_m, ferr_m, perr_m, ovr_m, valid_l, busy_l}, 0);
    tick_wait(3);

    send_frame(8'hA5, 1'b1, 1, 1'b0, 1'b0);
    chk("a5_data", data_m, 8'hA5);
    do_read();
    tick_wait(2);

    send_frame(8'h1E, 1'b1, 1, 1'b0, 1'b0);
    chk("1e_msb", data_m, 8'h1E);
    chk("1e_lsb", data_l, 8'h78);
    do_read();
    tick_wait(2);

    // False start: low for 4 ticks only.
    drive(1'b0);
    tick_wait(2);
    #1;
    chk("false_start_busy", busy_m, 1);
    tick_wait(2);
    drive(1'b1);
    tick_wait(8);
    #1;
    chk("false_start_idle", {busy_m, busy_l}, 0);
    chk("false_start_valid", valid_m, mvalid);
    tick_wait(2);

    send_frame(8'h3C, 1'b0, 2, 1'b0, 1'b0);
    tick_wait(2);
    send_frame(8'h55, 1'b1, 1, 1'b0, 1'b0);
    chk("55_data", data_m, 8'h55);
    do_read();
    tick_wait(2);

    send_frame(8'h11, 1'b1, 1, 1'b0, 1'b0);
    tick_wait(1);
    send_frame(8'h22, 1'b1, 1, 1'b0, 1'b0);
    chk("overrun_keeps", data_m, 8'h11);
    tick_wait(1);
    send_frame(8'h22, 1'b1, 1, 1'b0, 1'b1);
    chk("rd_same_cycle_data", data_m, 8'h22);
    chk("rd_same_cycle_valid", valid_m, 1);
    do_read();
    tick_wait(2);

    // Reset mid-DATA with an unread word pending.
    send_frame(8'h5A, 1'b1, 1, 1'b0, 1'b0);
    tick_wait(2);
    drive(1'b0);
    tick_wait(Os);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1);
      tick_wait(Os);
    end
    #1;
    chk("mid_frame_busy", busy_m, 1);
    do_reset();
    #1;
    chk("mid_rst_data", {data_m, data_l}, 0);
    chk("mid_rst_flags", {valid_m, busy_m, ferr_m, perr_m, ovr_m, valid_l, busy_l}, 0);
    tick_wait(3);
    send_frame(8'h81, 1'b1, 1, 1'b0, 1'b0);
    chk("81_data", data_m, 8'h81);
    do_read();
    tick_wait(2);

`ifdef USART_RX_PARITY_EN
    send_frame(8'hA5, 1'b1, 1, 1'b1, 1'b0);
    tick_wait(2);
    send_frame(8'hA5, 1'b1, 1, 1'b0, 1'b0);
    chk("par_ok_data", data_m, 8'hA5);
    do_read();
    tick_wait(2);
`endif

    for (int n = 0; n < 16; n++) begin
      w  = 8'($urandom_range(0, 255));
      sv = ($urandom_range(0, 7) != 0);
      send_frame(w, sv, sv ? 1 : int'($urandom_range(1, 2)),
                 ($urandom_range(0, 5) == 0), 1'b0);
      if ($urandom_range(0, 3) != 0) do_read();
      tick_wait($urandom_range(1, 6));
    end

    #1;
    chk("final_sb_empty", sb_q.size(), 0);
    chk("final_valid", valid_m, mvalid);
    if (mvalid) chk("final_data", data_m, mdata);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
